// File: rtl/algo_hash_pkg.sv
// Shared types for the hash engine update path: FSM states and request bundle.
package algo_hash_pkg;

  localparam int KYWIDTH = 32;
  localparam int DTWIDTH = 32;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_GAP
  } state_e;

  typedef struct packed {
    logic [KYWIDTH-1:0] key;
    logic [DTWIDTH-1:0] din;
    logic               del;
  } req_t;

endpackage

// File: rtl/algo_hash_upd_cap.sv
// One-entry capture register with valid/ready intake and a grant clear.
module algo_hash_upd_cap
  import algo_hash_pkg::*;
#(
  parameter type T = req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_i,
  output logic rdy_o,
  input  T     req_i,
  input  logic clr_i,
  output logic full_o,
  output T     req_o
);

  logic full_q, full_d;
  T     req_q, req_d;

  assign rdy_o  = !full_q;
  assign full_o = full_q;
  assign req_o  = req_q;

  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    if (clr_i) full_d = 1'b0;
    if (vld_i && !full_q) begin
      full_d = 1'b1;
      req_d  = req_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

endmodule

// File: rtl/algo_hash_upd_arb.sv
// Round-robin update arbiter/pacer for the hash engine update port.
// Define HASH_UPD_ARB_STAT_EN to add issue and blocked-cycle counters.
module algo_hash_upd_arb #(
  parameter int KYWIDTH = 32,
  parameter int DTWIDTH = 32,
  parameter int UPGAP   = 2,
  parameter int BITGAP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               freeze,
  input  logic               up_bp,
  input  logic               r0_vld,
  output logic               r0_rdy,
  input  logic [KYWIDTH-1:0] r0_key,
  input  logic [DTWIDTH-1:0] r0_din,
  input  logic               r0_del,
  input  logic               r1_vld,
  output logic               r1_rdy,
  input  logic [KYWIDTH-1:0] r1_key,
  input  logic [DTWIDTH-1:0] r1_din,
  input  logic               r1_del,
  output logic               up_en,
  output logic [KYWIDTH-1:0] up_key,
  output logic [DTWIDTH-1:0] up_din,
  output logic               up_del,
  output logic               busy
`ifdef HASH_UPD_ARB_STAT_EN
  ,
  output logic [15:0]        st_r0cnt,
  output logic [15:0]        st_r1cnt,
  output logic [15:0]        st_blkcnt
`endif
);
  import algo_hash_pkg::*;

  typedef struct packed {
    logic [KYWIDTH-1:0] key;
    logic [DTWIDTH-1:0] din;
    logic               del;
  } upd_t;

  localparam logic [BITGAP-1:0] GAPLD =
    (UPGAP > 0) ? BITGAP'(UPGAP - 1) : '0;

  state_e            state_q, state_d;
  logic [BITGAP-1:0] gap_q, gap_d;
  logic              rr_q, rr_d;
  logic              upen_q, upen_d;
  upd_t              out_q, out_d;

  upd_t in0, in1, c0, c1;
  logic f0, f1, g0, g1;
  logic both, coll, pick, elig;

  assign in0 = {r0_key, r0_din, r0_del};
  assign in1 = {r1_key, r1_din, r1_del};

  algo_hash_upd_cap #(.T(upd_t)) u_cap0 (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (r0_vld),
    .rdy_o  (r0_rdy),
    .req_i  (in0),
    .clr_i  (g0),
    .full_o (f0),
    .req_o  (c0)
  );

  algo_hash_upd_cap #(.T(upd_t)) u_cap1 (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (r1_vld),
    .rdy_o  (r1_rdy),
    .req_i  (in1),
    .clr_i  (g1),
    .full_o (f1),
    .req_o  (c1)
  );

  assign both = f0 && f1;
  // A same-key insert/delete pair always issues the delete first.
  assign coll = both && (c0.key == c1.key) && (c0.del ^ c1.del);

  always_comb begin
    pick = f1;
    unique case (1'b1)
      coll:          pick = c1.del;
      both && !coll: pick = rr_q;
      default:       pick = f1;
    endcase
  end

  assign elig = (state_q == S_IDLE) && ready && !freeze
             && !up_bp && (f0 || f1);
  assign g0 = elig && !pick;
  assign g1 = elig && pick;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    upen_d  = 1'b0;
    out_d   = out_q;
    if (!ready) begin
      state_d = S_INIT;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        S_INIT: state_d = S_IDLE;
        S_IDLE: begin
          if (elig) begin
            upen_d = 1'b1;
            out_d  = pick ? c1 : c0;
            if (both && !coll) rr_d = !rr_q;
            if (UPGAP > 0) begin
              state_d = S_GAP;
              gap_d   = GAPLD;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) state_d = S_IDLE;
          else             gap_d   = gap_q - 1'b1;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_INIT;
      gap_q   <= '0;
      rr_q    <= 1'b0;
      upen_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      upen_q  <= upen_d;
      out_q   <= out_d;
    end
  end

  assign up_en  = upen_q;
  assign up_key = out_q.key;
  assign up_din = out_q.din;
  assign up_del = out_q.del;
  assign busy   = f0 || f1 || (state_q == S_GAP);

`ifdef HASH_UPD_ARB_STAT_EN
  logic [15:0] r0cnt_q, r1cnt_q, blkcnt_q;
  logic        blk;

  assign blk = (state_q == S_IDLE) && ready && (f0 || f1)
            && (freeze || up_bp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r0cnt_q  <= '0;
      r1cnt_q  <= '0;
      blkcnt_q <= '0;
    end else begin
      if (g0 && r0cnt_q != 16'hFFFF) r0cnt_q <= r0cnt_q + 16'd1;
      if (g1 && r1cnt_q != 16'hFFFF) r1cnt_q <= r1cnt_q + 16'd1;
      if (blk && blkcnt_q != 16'hFFFF) blkcnt_q <= blkcnt_q + 16'd1;
    end
  end

  assign st_r0cnt  = r0cnt_q;
  assign st_r1cnt  = r1cnt_q;
  assign st_blkcnt = blkcnt_q;
`endif

endmodule

// File: tb/tb_algo_hash_upd_arb.sv
// Scoreboard bench for algo_hash_upd_arb with directed vectors.
module tb_algo_hash_upd_arb;

  logic        clk = 1'b0;
  logic        rst, ready, freeze, up_bp;
  logic        r0_vld, r0_rdy, r0_del;
  logic        r1_vld, r1_rdy, r1_del;
  logic [31:0] r0_key, r0_din, r1_key, r1_din;
  logic        up_en, up_del, busy;
  logic [31:0] up_key, up_din;
`ifdef HASH_UPD_ARB_STAT_EN
  logic [15:0] st_r0cnt, st_r1cnt, st_blkcnt;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] key;
    logic [31:0] din;
    logic        del;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [31:0] ka [3];
  logic [31:0] kb [2];

  algo_hash_upd_arb #(
    .KYWIDTH(32), .DTWIDTH(32), .UPGAP(2), .BITGAP(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ready  (ready),
    .freeze (freeze),
    .up_bp  (up_bp),
    .r0_vld (r0_vld),
    .r0_rdy (r0_rdy),
    .r0_key (r0_key),
    .r0_din (r0_din),
    .r0_del (r0_del),
    .r1_vld (r1_vld),
    .r1_rdy (r1_rdy),
    .r1_key (r1_key),
    .r1_din (r1_din),
    .r1_del (r1_del),
    .up_en  (up_en),
    .up_key (up_key),
    .up_din (up_din),
    .up_del (up_del),
    .busy   (busy)
`ifdef HASH_UPD_ARB_STAT_EN
    ,
    .st_r0cnt  (st_r0cnt),
    .st_r1cnt  (st_r1cnt),
    .st_blkcnt (st_blkcnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_up(input int c, input logic [31:0] k,
                           input logic [31:0] d, input logic dl);
    exp_t e;
    e.cyc = c; e.key = k; e.din = d; e.del = dl;
    sbq.push_back(e);
  endtask

  task automatic drv0(input logic v, input logic [31:0] k,
                      input logic [31:0] d, input logic dl);
    r0_vld = v; r0_key = k; r0_din = d; r0_del = dl;
  endtask

  task automatic drv1(input logic v, input logic [31:0] k,
                      input logic [31:0] d, input logic dl);
    r1_vld = v; r1_key = k; r1_din = d; r1_del = dl;
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (up_en === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d got_key=%0h exp=none",
                 cyc, up_key);
      end else begin
        e = sbq.pop_front();
        chk("strobe_cyc", 64'(cyc), 64'(e.cyc));
        chk("up_key", 64'(up_key), 64'(e.key));
        chk("up_din", 64'(up_din), 64'(e.din));
        chk("up_del", 64'(up_del), 64'(e.del));
      end
    end
  end

  initial begin
    int c, i0, i1;
    rst = 1'b0; ready = 1'b0; freeze = 1'b0; up_bp = 1'b0;
    drv0(1'b0, '0, '0, 1'b0);
    drv1(1'b0, '0, '0, 1'b0);
    ka[0] = 32'h100; ka[1] = 32'h101; ka[2] = 32'h102;
    kb[0] = 32'h200; kb[1] = 32'h201;
    tick(3);
    chk("rst_up_en", 64'(up_en), 64'd0);
    chk("rst_r0_rdy", 64'(r0_rdy), 64'd1);
    chk("rst_r1_rdy", 64'(r1_rdy), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_up_key", 64'(up_key), 64'd0);
    rst = 1'b1;
    tick(2);
    ready = 1'b1;
    tick(3);

    // single r0 insert: strobe two cycles after the drive cycle
    c = cyc;
    drv0(1'b1, 32'h11, 32'hA, 1'b0);
    expect_up(c + 2, 32'h11, 32'hA, 1'b0);
    tick();
    r0_vld = 1'b0;
    chk("t1_r0_rdy_low", 64'(r0_rdy), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_r0_rdy_back", 64'(r0_rdy), 64'd1);
    tick(4);
    chk("t1_drain", 64'(sbq.size()), 64'd0);

    // both requesters streaming: alternate with UPGAP+1 spacing
    c = cyc;
    expect_up(c + 2,  ka[0], ka[0] + 32'h1000, 1'b0);
    expect_up(c + 5,  kb[0], kb[0] + 32'h1000, 1'b0);
    expect_up(c + 8,  ka[1], ka[1] + 32'h1000, 1'b0);
    expect_up(c + 11, kb[1], kb[1] + 32'h1000, 1'b0);
    expect_up(c + 14, ka[2], ka[2] + 32'h1000, 1'b0);
    i0 = 0; i1 = 0;
    for (int k = 0; k < 16; k++) begin
      if (r0_rdy && i0 < 3) begin
        drv0(1'b1, ka[i0], ka[i0] + 32'h1000, 1'b0);
        i0++;
      end else r0_vld = 1'b0;
      if (r1_rdy && i1 < 2) begin
        drv1(1'b1, kb[i1], kb[i1] + 32'h1000, 1'b0);
        i1++;
      end else r1_vld = 1'b0;
      tick();
    end
    r0_vld = 1'b0; r1_vld = 1'b0;
    tick(3);
    chk("t2_drain", 64'(sbq.size()), 64'd0);

    // same-key collision: delete (r1) first despite rr=0
    c = cyc;
    freeze = 1'b1;
    drv0(1'b1, 32'h5A, 32'h1, 1'b0);
    drv1(1'b1, 32'h5A, 32'h2, 1'b1);
    tick();
    r0_vld = 1'b0; r1_vld = 1'b0;
    chk("t3_frozen_busy", 64'(busy), 64'd1);
    freeze = 1'b0;
    expect_up(c + 2, 32'h5A, 32'h2, 1'b1);
    expect_up(c + 5, 32'h5A, 32'h1, 1'b0);
    tick(8);
    chk("t3_drain", 64'(sbq.size()), 64'd0);

    // rr left at 0 by the collision: r0 wins the next tie
    c = cyc;
    freeze = 1'b1;
    drv0(1'b1, 32'h21, 32'h3, 1'b0);
    drv1(1'b1, 32'h22, 32'h4, 1'b0);
    tick();
    r0_vld = 1'b0; r1_vld = 1'b0;
    freeze = 1'b0;
    expect_up(c + 2, 32'h21, 32'h3, 1'b0);
    expect_up(c + 5, 32'h22, 32'h4, 1'b0);
    tick(8);
    chk("t3b_drain", 64'(sbq.size()), 64'd0);

    // up_bp holds r0 for 10 blocked cycles
    c = cyc;
    up_bp = 1'b1;
    drv0(1'b1, 32'h44, 32'h4, 1'b1);
    tick();
    r0_vld = 1'b0;
    tick(5);
    chk("t4_r0_rdy_held", 64'(r0_rdy), 64'd0);
    tick(5);
    up_bp = 1'b0;
    expect_up(c + 12, 32'h44, 32'h4, 1'b1);
    tick(5);
    chk("t4_drain", 64'(sbq.size()), 64'd0);
`ifdef HASH_UPD_ARB_STAT_EN
    chk("st_blkcnt", 64'(st_blkcnt), 64'd10);
    chk("st_r0cnt", 64'(st_r0cnt), 64'd7);
    chk("st_r1cnt", 64'(st_r1cnt), 64'd4);
`endif

    // ready drops in the gap with r1 captured
    c = cyc;
    drv0(1'b1, 32'h51, 32'h5, 1'b0);
    expect_up(c + 2, 32'h51, 32'h5, 1'b0);
    tick();
    r0_vld = 1'b0;
    tick();
    drv1(1'b1, 32'h52, 32'h6, 1'b0);
    ready = 1'b0;
    tick();
    r1_vld = 1'b0;
    tick(3);
    chk("t5_r1_rdy_low", 64'(r1_rdy), 64'd0);
    chk("t5_busy", 64'(busy), 64'd1);
    ready = 1'b1;
    c = cyc;
    expect_up(c + 2, 32'h52, 32'h6, 1'b0);
    tick(6);
    chk("t5_drain", 64'(sbq.size()), 64'd0);

    // reset in the grant cycle discards both captures
    drv0(1'b1, 32'h61, 32'h7, 1'b0);
    drv1(1'b1, 32'h62, 32'h8, 1'b0);
    tick();
    r0_vld = 1'b0; r1_vld = 1'b0;
    rst = 1'b0;
    tick();
    chk("t6_up_en", 64'(up_en), 64'd0);
    chk("t6_r0_rdy", 64'(r0_rdy), 64'd1);
    chk("t6_r1_rdy", 64'(r1_rdy), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_up_key", 64'(up_key), 64'd0);
`ifdef HASH_UPD_ARB_STAT_EN
    chk("t6_st_r0cnt", 64'(st_r0cnt), 64'd0);
    chk("t6_st_blkcnt", 64'(st_blkcnt), 64'd0);
`endif
    rst = 1'b1;
    tick(8);

    // recovery after reset
    c = cyc;
    drv1(1'b1, 32'h71, 32'h9, 1'b1);
    expect_up(c + 2, 32'h71, 32'h9, 1'b1);
    tick();
    r1_vld = 1'b0;
    tick(5);
    chk("final_drain", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
